// File: rtl/gb_pad_reader_if.sv
// Pin and result bundle between the pad reader and its surroundings
// (pad connector on one side, gb core joystick bus on the other).
interface gb_pad_reader_if;
  logic       pad_latch;
  logic       pad_clk;
  logic       pad_data;
  logic [7:0] joystick;
  logic       pad_present;
  logic       poll_done;

  modport master (
    output pad_latch, pad_clk, joystick, pad_present, poll_done,
    input  pad_data
  );

  modport slave (
    input  pad_latch, pad_clk, joystick, pad_present, poll_done,
    output pad_data
  );
endinterface

// File: rtl/gb_pad_reader.sv
// NES-style serial pad poller for the gb core: periodic latch/shift of 16 bits,
// presence detection and two-poll debounce onto an active-high joystick bus.
module gb_pad_reader #(
  parameter int unsigned HALF_BIT    = 21,
  parameter int unsigned POLL_PERIOD = 69905
) (
  input logic             clk,
  input logic             reset_n,
  gb_pad_reader_if.master pad
);

  localparam int unsigned PCW = $clog2(POLL_PERIOD);
  localparam int unsigned HW  = $clog2(2 * HALF_BIT);

  localparam logic [PCW-1:0] POLL_LAST  = PCW'(POLL_PERIOD - 1);
  localparam logic [HW-1:0]  HALF_LAST  = HW'(HALF_BIT - 1);
  localparam logic [HW-1:0]  LATCH_LAST = HW'(2 * HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    GAP,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic           sync1_q, sync1_d;
  logic           sync2_q, sync2_d;
  logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
  logic [HW-1:0]  phase_q, phase_d;
  logic [3:0]     bit_q, bit_d;
  logic [15:0]    raw_q, raw_d;
  logic [7:0]     prev_q, prev_d;
  logic [7:0]     joy_q, joy_d;
  logic           present_q, present_d;
  logic           done_q, done_d;
  logic           latch_q, latch_d;
  logic           pclk_q, pclk_d;
  logic           poll_start;
  logic [7:0]     cand;

  always_comb begin
    sync1_d    = pad.pad_data;
    sync2_d    = sync1_q;
    poll_start = (poll_cnt_q == POLL_LAST);
    poll_cnt_d = poll_start ? '0 : poll_cnt_q + 1'b1;

    // Serial order A,B,Sel,Start,Up,Down,Left,Right -> {St,Se,B,A,Dn,Up,Lf,Rt}
    cand = {~raw_q[3], ~raw_q[2], ~raw_q[1], ~raw_q[0],
            ~raw_q[5], ~raw_q[4], ~raw_q[6], ~raw_q[7]};

    state_d   = state_q;
    phase_d   = phase_q + 1'b1;
    bit_d     = bit_q;
    raw_d     = raw_q;
    prev_d    = prev_q;
    joy_d     = joy_q;
    present_d = present_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (poll_start) state_d = LATCH;
      end
      LATCH: begin
        if (phase_q == LATCH_LAST) begin
          state_d = GAP;
          phase_d = '0;
        end
      end
      GAP: begin
        if (phase_q == HALF_LAST) begin
          state_d = SHIFT_LO;
          phase_d = '0;
          bit_d   = '0;
        end
      end
      SHIFT_LO: begin
        if (phase_q == HALF_LAST) begin
          raw_d[bit_q] = sync2_q;
          state_d      = SHIFT_HI;
          phase_d      = '0;
        end
      end
      SHIFT_HI: begin
        if (phase_q == HALF_LAST) begin
          phase_d = '0;
          if (bit_q == 4'd15) begin
            state_d = DONE;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = SHIFT_LO;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        phase_d = '0;
        done_d  = 1'b1;
        // A standard pad drives 1s after its 8 buttons; anything else means absent.
        if (&raw_q[15:8]) begin
          present_d = 1'b1;
          if (cand == prev_q) joy_d = cand;
          prev_d = cand;
        end else begin
          present_d = 1'b0;
          joy_d     = '0;
          prev_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    latch_d = (state_d == LATCH);
    pclk_d  = (state_d != SHIFT_LO);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      poll_cnt_q <= '0;
      phase_q    <= '0;
      bit_q      <= '0;
      raw_q      <= '0;
      prev_q     <= '0;
      joy_q      <= '0;
      present_q  <= 1'b0;
      done_q     <= 1'b0;
      latch_q    <= 1'b0;
      pclk_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      poll_cnt_q <= poll_cnt_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      raw_q      <= raw_d;
      prev_q     <= prev_d;
      joy_q      <= joy_d;
      present_q  <= present_d;
      done_q     <= done_d;
      latch_q    <= latch_d;
      pclk_q     <= pclk_d;
    end
  end

  assign pad.pad_latch   = latch_q;
  assign pad.pad_clk     = pclk_q;
  assign pad.joystick    = joy_q;
  assign pad.pad_present = present_q;
  assign pad.poll_done   = done_q;

endmodule

// File: tb/tb_gb_pad_reader.sv
// Bench for gb_pad_reader: behavioural NES pad, per-poll scoreboard of
// {pad_present, joystick}, pad waveform timing and reset behaviour.
module tb_gb_pad_reader;

  localparam int H = 3;
  localparam int P = 150;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  gb_pad_reader_if pif ();

  gb_pad_reader #(.HALF_BIT(H), .POLL_PERIOD(P)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pad     (pif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0]  exp_q[$];
  logic [8:0]  sb_e;
  int          sb_idx = 0;
  logic [15:0] raw_vec = 16'hFFFF;
  logic [15:0] shreg   = 16'hFFFF;
  logic        pclk_prev = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pad model: latch loads the 16-bit shift register, each pad_clk rise shifts.
  initial pif.pad_data = 1'b1;
  always @(negedge clk) begin
    if (pif.pad_latch) shreg = raw_vec;
    else if (pif.pad_clk && !pclk_prev) shreg = {1'b1, shreg[15:1]};
    pclk_prev    = pif.pad_clk;
    pif.pad_data = shreg[0];
  end

  // Monitor: scoreboard pop on poll_done, waveform timing, output stability.
  int   cyc = 0;
  int   illegal = 0;
  int   t_lrise = 0, t_ref = 0, t_fall = 0, n_pulse = 0;
  logic wave_ok = 1'b0, in_poll = 1'b0;
  logic last_latch = 1'b0, last_pclk = 1'b1, last_done = 1'b0, last_pres = 1'b0;
  logic [7:0] last_joy = '0;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      in_poll = 1'b0;
    end else begin
      if (({pif.pad_present, pif.joystick} !== {last_pres, last_joy}) && !pif.poll_done)
        illegal++;
      if (pif.poll_done && last_done) illegal++;

      if (pif.pad_latch && !last_latch) begin
        t_lrise = cyc; n_pulse = 0; wave_ok = 1'b1; in_poll = 1'b1;
      end
      if (!pif.pad_latch && last_latch) begin
        check("latch_width", cyc - t_lrise, 2 * H);
        t_ref = cyc;
      end
      if (in_poll && !pif.pad_clk && last_pclk) begin
        if (cyc - t_ref != H) wave_ok = 1'b0;
        t_fall = cyc;
      end
      if (in_poll && pif.pad_clk && !last_pclk) begin
        if (cyc - t_fall != H) wave_ok = 1'b0;
        t_ref = cyc;
        n_pulse++;
      end

      if (pif.poll_done) begin
        if (in_poll) begin
          check("done_latency", cyc - t_lrise, 35 * H + 1);
          check("clk_pulses", n_pulse, 16);
          check("pulse_widths", {31'd0, wave_ok}, 32'd1);
          in_poll = 1'b0;
        end
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sb_unexpected: poll_done with empty queue, joystick=0x%0h", pif.joystick);
        end else begin
          sb_e = exp_q.pop_front();
          check($sformatf("present[poll %0d]", sb_idx), {31'd0, pif.pad_present}, {31'd0, sb_e[8]});
          check($sformatf("joystick[poll %0d]", sb_idx), {24'd0, pif.joystick}, {24'd0, sb_e[7:0]});
        end
        sb_idx++;
      end
    end
    last_latch = pif.pad_latch;
    last_pclk  = pif.pad_clk;
    last_done  = pif.poll_done;
    last_pres  = pif.pad_present;
    last_joy   = pif.joystick;
  end

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 2 * P + 100; i++) begin
      @(negedge clk);
      if (pif.poll_done) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL %s: no poll_done within %0d cycles", name, 2 * P + 100);
    end
  endtask

  task automatic do_poll(input logic [15:0] raw, input logic pres, input logic [7:0] joy);
    raw_vec = raw;
    exp_q.push_back({pres, joy});
    wait_done($sformatf("poll_timeout raw=0x%0h", raw));
  endtask

  task automatic release_and_time(input string name);
    int latch_at = 0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= P + 20; i++) begin
      @(negedge clk);
      if (i == P / 2)
        check({name, "_idle_outputs"},
              {20'd0, pif.pad_latch, pif.pad_clk, pif.pad_present, pif.poll_done, pif.joystick},
              {20'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
      if (pif.pad_latch) begin latch_at = i; break; end
    end
    check(name, latch_at, P);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check("reset_outputs",
          {20'd0, pif.pad_latch, pif.pad_clk, pif.pad_present, pif.poll_done, pif.joystick},
          {20'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});

    // Debounce: A pressed, then released
    raw_vec = 16'hFFFE;
    exp_q.push_back({1'b1, 8'h00});
    release_and_time("first_latch");
    wait_done("poll_timeout first");
    do_poll(16'hFFFE, 1'b1, 8'h10);
    do_poll(16'hFFFF, 1'b1, 8'h10);
    do_poll(16'hFFFF, 1'b1, 8'h00);
    // Mapping
    do_poll(16'hFF0F, 1'b1, 8'h00);
    do_poll(16'hFF0F, 1'b1, 8'h0F);
    do_poll(16'hFFF0, 1'b1, 8'h0F);
    do_poll(16'hFFF0, 1'b1, 8'hF0);
    // Disconnect / reconnect
    do_poll(16'h0000, 1'b0, 8'h00);
    do_poll(16'hFFFF, 1'b1, 8'h00);
    // Right held, single-poll glitch to B must not reach the bus
    do_poll(16'hFF7F, 1'b1, 8'h00);
    do_poll(16'hFF7F, 1'b1, 8'h01);
    do_poll(16'hFFFD, 1'b1, 8'h01);
    do_poll(16'hFF7F, 1'b1, 8'h01);
    // One trailing bit low is not a standard pad
    do_poll(16'h7FFF, 1'b0, 8'h00);
    do_poll(16'hFF7F, 1'b1, 8'h00);
    do_poll(16'hFF7F, 1'b1, 8'h01);

    // Async reset in the middle of bit 7
    begin
      bit   got_latch = 1'b0;
      int   falls = 0;
      logic pc_prev = 1'b1;
      raw_vec = 16'hFF7F;
      for (int i = 0; i < 2 * P; i++) begin
        @(negedge clk);
        if (pif.pad_latch) begin got_latch = 1'b1; break; end
      end
      for (int i = 0; i < 40 * H && got_latch && falls < 8; i++) begin
        @(negedge clk);
        if (!pif.pad_clk && pc_prev) falls++;
        pc_prev = pif.pad_clk;
      end
      check("reach_bit7", falls, 8);
      check("pre_reset_joystick", {24'd0, pif.joystick}, 32'h01);
      #2 reset_n = 1'b0;
      #1 check("async_reset_outputs",
               {20'd0, pif.pad_latch, pif.pad_clk, pif.pad_present, pif.poll_done, pif.joystick},
               {20'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
      repeat (3) @(negedge clk);
    end
    exp_q.push_back({1'b1, 8'h00});
    release_and_time("latch_after_reset");
    wait_done("poll_timeout after reset");
    do_poll(16'hFF7F, 1'b1, 8'h01);

    repeat (5) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    check("illegal_output_changes", illegal, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
